// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: PC sequencing, one outstanding imem read, and a
// DEPTH-entry {instr, pc} queue feeding the datapath over a valid/ready handshake.
module mips_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  // Handshake: the head transfers on a rising edge where instr_valid && instr_ready;
  // instr_valid never depends on instr_ready, and a redirect still honours that transfer.
  localparam int              PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]  FULL  = (PTR_W + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic             discard_q, discard_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [31:0]      mem_instr_q [DEPTH];
  logic [31:0]      mem_pc_q    [DEPTH];

  logic issue;
  logic push;
  logic pop;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    discard_d = discard_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    push      = 1'b0;
    pop       = (count_q != '0) && instr_ready;
    issue     = !reset && (state_q == S_IDLE) && (count_q != FULL) && !redirect;

    case (state_q)
      S_IDLE: if (issue) state_d = S_WAIT;
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d   = S_IDLE;
          discard_d = 1'b0;
          push      = !discard_q && !redirect;
        end else if (redirect) begin
          discard_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect wipes the queue; any same-cycle pop is already consumed downstream.
    if (redirect) begin
      pc_d     = redirect_pc & ~32'h3;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        pc_d     = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      discard_q <= discard_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= imem_rdata;
      mem_pc_q[wr_ptr_q]    <= pc_q;
    end
  end

  assign imem_req    = issue;
  assign imem_addr   = pc_q;
  assign instr_valid = (count_q != '0);
  assign instr       = instr_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? mem_pc_q[rd_ptr_q]    : 32'h0;

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: a latency-configurable imem model plus a queue-based
// reference of the fetch front end, compared against the DUT every cycle.
module tb_mips_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  mips_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference state: expected queue of {instr, pc}, next fetch PC, one-read tracking.
  logic [63:0] exp_q[$];
  logic [31:0] m_pc      = RESET_PC;
  bit          m_out     = 1'b0;
  bit          m_discard = 1'b0;

  // imem model
  bit          mem_pend = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_addr = 32'h0;

  bit          obs_req;
  logic [31:0] obs_addr;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit rdy, input bit redir,
                      input logic [31:0] rpc, input int lat, input bit stray);
    bit          e_req;
    bit          pop_m;
    logic [63:0] head;
    @(negedge clock);
    reset       = rst;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rst) mem_pend = 1'b0;
    else if (mem_pend) begin
      if (mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = word_of(mem_addr);
        mem_pend    = 1'b0;
      end else mem_cnt--;
    end
    if (stray) begin
      imem_rvalid = 1'b1;
      imem_rdata  = $urandom;
    end
    #1;
    e_req = !rst && !m_out && (exp_q.size() < DEPTH) && !redir;
    check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
    if (e_req || rst) check("imem_addr", imem_addr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
    head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
    check("instr", instr, head[63:32]);
    check("instr_pc", instr_pc, head[31:0]);
    obs_req  = imem_req;
    obs_addr = imem_addr;
    if (imem_req && !rst) begin
      mem_pend = 1'b1;
      mem_cnt  = lat - 1;
      mem_addr = imem_addr;
    end
    // Advance the reference to the state after this clock edge.
    if (rst) begin
      exp_q.delete();
      m_pc = RESET_PC; m_out = 1'b0; m_discard = 1'b0;
    end else begin
      pop_m = (exp_q.size() != 0) && rdy;
      if (redir) begin
        exp_q.delete();
        m_pc = {rpc[31:2], 2'b00};
        if (m_out) begin
          if (imem_rvalid) begin m_out = 1'b0; m_discard = 1'b0; end
          else m_discard = 1'b1;
        end
      end else begin
        if (pop_m) void'(exp_q.pop_front());
        if (m_out && imem_rvalid) begin
          if (m_discard) m_discard = 1'b0;
          else begin
            exp_q.push_back({imem_rdata, m_pc});
            m_pc = m_pc + 32'd4;
          end
          m_out = 1'b0;
        end
        if (e_req) m_out = 1'b1;
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, 1, 1'b0);
  endtask

  int nreq;
  bit seen;

  initial begin
    reset = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    imem_rvalid = 1'b0; imem_rdata = 32'h0;

    // Reset release, L=1, consumer always ready.
    do_reset(3);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);

    // Consumer stalled: exactly DEPTH requests, then a single pop frees one slot.
    do_reset(2);
    nreq = 0;
    for (int i = 0; i < 14; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
      if (obs_req) nreq++;
    end
    check("full_req_count", nreq, DEPTH);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    check("refill_addr", obs_addr, 32'h10);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);

    // Redirect while waiting; stale response three cycles later is dropped.
    do_reset(2);
    step(1'b0, 1'b1, 1'b0, 32'h0, 5, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103, 1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
      if (obs_req) seen = 1'b1;
    end
    check("redir_seen", {31'b0, seen}, 32'h1);
    check("redir_addr", obs_addr, 32'h0000_0100);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);

    // Redirect coinciding with a response and a consumer pop.
    do_reset(2);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 2, 1'b0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 32'h0000_0200, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    check("coinc_req", {31'b0, obs_req}, 32'h1);
    check("coinc_addr", obs_addr, 32'h0000_0200);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    check("wrap_addr0", obs_addr, 32'hFFFF_FFFC);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);
    check("wrap_addr1", obs_addr, 32'h0000_0000);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);

    // Reset mid-WAIT, then a stray response from the aborted read.
    step(1'b0, 1'b1, 1'b1, 32'h0000_0400, 1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h0, 6, 1'b0);
    do_reset(1);
    step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b1);
    check("rst_first_addr", obs_addr, RESET_PC);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 32'h0, 1, 1'b0);

    // Randomised traffic: latency, stalls, redirects (some misaligned, some near wrap).
    for (int i = 0; i < 600; i++) begin
      logic [31:0] tgt;
      bit          rd;
      rd  = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 3))
        0:       tgt = 32'hFFFF_FFF0 | $urandom_range(0, 15);
        default: tgt = $urandom;
      endcase
      step(1'b0, ($urandom_range(0, 2) != 0), rd, tgt, $urandom_range(1, 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
